ifence_sequencer: RTL

- Multi-cycle controller that sequences a FENCE.I for the two-stage pipeline.
- Triggered by the ifence decode signal from the control unit. It stalls the pipeline, writes back the data cache, then invalidates the instruction cache.
- Finally it issues a one-cycle fetch restart at the instruction following the fence.
- Sits between the execute stage, the cache flush controls and the fetch stage.

---
 rtl/ifence_sequencer.sv | 118 +++++++++++
 1 files changed

// File: rtl/ifence_sequencer.sv
// FENCE.I sequencer: stall the pipeline, write back the D$, invalidate the I$, then restart fetch.
// Optional per-state flush watchdog is enabled by defining IFENCE_WATCHDOG_EN.
module ifence_sequencer #(
   parameter int DCACHE_PRESENT = 1,
   parameter int ICACHE_PRESENT = 1,
   parameter int WDOG_CYCLES    = 1024
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ifence_req,
   input  logic        ex_stall,
   input  logic [31:0] ex_pc,
   input  logic        dflush_done,
   input  logic        iflush_done,
   output logic        dflush,
   output logic        iflush,
   output logic        pipe_stall,
   output logic        fetch_restart,
   output logic [31:0] restart_pc,
   output logic        busy,
   output logic        fence_err
);

   typedef enum logic [1:0] {S_IDLE, S_DFLUSH, S_IFLUSH, S_RESTART} state_t;

   state_t      state_q, state_d;
   logic        armed_q, armed_d;
   logic [31:0] restart_pc_q, restart_pc_d;
   logic        accept;
   logic        wdog_expire;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q      <= S_IDLE;
         armed_q      <= 1'b1;
         restart_pc_q <= '0;
      end else begin
         state_q      <= state_d;
         armed_q      <= armed_d;
         restart_pc_q <= restart_pc_d;
      end
   end

   // armed blocks re-triggering on the same fence until ifence_req has been seen low.
   always_comb begin
      accept       = (state_q == S_IDLE) && ifence_req && armed_q && !ex_stall;
      state_d      = state_q;
      armed_d      = armed_q | ~ifence_req;
      restart_pc_d = restart_pc_q;
      if (accept) begin
         armed_d      = 1'b0;
         restart_pc_d = ex_pc + 32'd4;
      end
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (DCACHE_PRESENT != 0)      state_d = S_DFLUSH;
               else if (ICACHE_PRESENT != 0) state_d = S_IFLUSH;
               else                          state_d = S_RESTART;
            end
         end
         S_DFLUSH: begin
            if (dflush_done)      state_d = (ICACHE_PRESENT != 0) ? S_IFLUSH : S_RESTART;
            else if (wdog_expire) state_d = S_RESTART;
         end
         S_IFLUSH: begin
            if (iflush_done || wdog_expire) state_d = S_RESTART;
         end
         S_RESTART: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy          = (state_q != S_IDLE);
      pipe_stall    = busy | accept;
      dflush        = (state_q == S_DFLUSH);
      iflush        = (state_q == S_IFLUSH);
      fetch_restart = (state_q == S_RESTART);
   end

   assign restart_pc = restart_pc_q;

`ifdef IFENCE_WATCHDOG_EN
   logic [15:0] wdog_cnt_q, wdog_cnt_d;
   logic        fence_err_q, fence_err_d;

   // A done pulse in the expiry cycle takes priority over the timeout.
   assign wdog_expire = (((state_q == S_DFLUSH) && !dflush_done) ||
                         ((state_q == S_IFLUSH) && !iflush_done)) &&
                        (wdog_cnt_q == 16'(WDOG_CYCLES - 1));

   always_comb begin
      fence_err_d = wdog_expire;
      wdog_cnt_d  = '0;
      if ((state_d == state_q) && ((state_q == S_DFLUSH) || (state_q == S_IFLUSH)))
         wdog_cnt_d = wdog_cnt_q + 16'd1;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wdog_cnt_q  <= '0;
         fence_err_q <= 1'b0;
      end else begin
         wdog_cnt_q  <= wdog_cnt_d;
         fence_err_q <= fence_err_d;
      end
   end

   assign fence_err = fence_err_q;
`else
   logic unused_wdog;
   assign unused_wdog = (WDOG_CYCLES > 0);
   assign wdog_expire = 1'b0;
   assign fence_err   = 1'b0;
`endif

endmodule
